// File: rtl/d_reg_pkg.sv
// Shared definitions for the universal register.
// Holds the mode encodings as a typed enum and a helper that identifies
// the modes which advance the shift counter.
package d_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_word_cnt.sv
// Shift counter with end-of-word pulse.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   step       - one shift/rotate executed this cycle
//   clr        - restart counting from zero (LOAD/CLEAR)
//   cnt        - shifts since last restart, wraps after WIDTH steps
//   word_done  - registered pulse, high for the cycle after the WIDTH-th step
module shift_word_cnt #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           step,
  input  logic                           clr,
  output logic [$clog2(WIDTH+1)-1:0]     cnt,
  output logic                           word_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (step) begin
        if (cnt == LAST) begin
          cnt       <= '0;
          word_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/d_reg_univ.sv
// Universal shift register: hold, parallel load, logical shift left/right
// with serial inputs, rotate left/right and clear, plus shift-count status.
// Ports:
//   clk, rstn       - clock, synchronous active-low reset
//   en, mode        - execute the operation selected by mode when en=1
//   d               - parallel load data
//   sin_l, sin_r    - serial-in bit for SHR (enters msb) / SHL (enters lsb)
//   q, qbar         - register state and its complement
//   sout_l, sout_r  - msb / lsb of q
//   shift_cnt       - shift/rotate ops since last LOAD, CLEAR or reset
//   word_done       - pulse after every WIDTH-th shift/rotate
//   mode_err        - pulse after an enabled reserved mode
module d_reg_univ
  import d_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_l,
  input  logic                       sin_r,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qbar,
  output logic                       sout_l,
  output logic                       sout_r,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       word_done,
  output logic                       mode_err
);

  mode_e mode_sel;
  logic  cnt_step;
  logic  cnt_clr;

  assign mode_sel = mode_e'(mode);
  assign cnt_step = en && is_shift(mode_sel);
  assign cnt_clr  = en && ((mode_sel == MODE_LOAD) || (mode_sel == MODE_CLEAR));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q        <= RST_VAL;
      mode_err <= 1'b0;
    end else begin
      mode_err <= 1'b0;
      if (en) begin
        case (mode_sel)
          MODE_LOAD:  q <= d;
          MODE_SHL:   q <= {q[WIDTH-2:0], sin_r};
          MODE_SHR:   q <= {sin_l, q[WIDTH-1:1]};
          MODE_ROL:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
          MODE_ROR:   q <= {q[0], q[WIDTH-1:1]};
          MODE_CLEAR: q <= RST_VAL;
          MODE_RSVD:  mode_err <= 1'b1;
          default:    q <= q;
        endcase
      end
    end
  end

  // Derived combinationally so the complement and serial outs track q
  // with no added latency.
  assign qbar   = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  shift_word_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .step      (cnt_step),
    .clr       (cnt_clr),
    .cnt       (shift_cnt),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_d_reg_univ.sv
// Self-checking bench for d_reg_univ (WIDTH=8, RST_VAL=0): directed
// scenarios followed by random traffic against an arithmetic reference model.
module tb_d_reg_univ;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn, en, sin_l, sin_r;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q, qbar;
  logic         sout_l, sout_r, word_done, mode_err;
  logic [3:0]   shift_cnt;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int m_q = 0, m_cnt = 0, m_done = 0, m_err = 0;

  d_reg_univ #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .qbar(qbar),
    .sout_l(sout_l), .sout_r(sout_r), .shift_cnt(shift_cnt),
    .word_done(word_done), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_update(input int r, input int e, input int md, input int dv,
                              input int sl, input int sr);
    if (r == 0) begin
      m_q = 0; m_cnt = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (e != 0) begin
        if (md >= 2 && md <= 5) begin
          case (md)
            2: m_q = ((m_q * 2) % 256) + sr;
            3: m_q = (m_q / 2) + sl * 128;
            4: m_q = ((m_q * 2) % 256) + (m_q / 128);
            default: m_q = (m_q / 2) + (m_q % 2) * 128;
          endcase
          m_done = (m_cnt + 1 == W) ? 1 : 0;
          m_cnt  = (m_cnt + 1) % W;
        end else if (md == 1) begin
          m_q = dv; m_cnt = 0;
        end else if (md == 6) begin
          m_q = 0; m_cnt = 0;
        end else if (md == 7) begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},         q,         64'(m_q));
    check({tag, ".qbar"},      qbar,      64'(255 - m_q));
    check({tag, ".sout_l"},    sout_l,    64'(m_q / 128));
    check({tag, ".sout_r"},    sout_r,    64'(m_q % 2));
    check({tag, ".shift_cnt"}, shift_cnt, 64'(m_cnt));
    check({tag, ".word_done"}, word_done, 64'(m_done));
    check({tag, ".mode_err"},  mode_err,  64'(m_err));
  endtask

  task automatic step(input string tag, input int r, input int e, input int md,
                      input int dv = 0, input int sl = 0, input int sr = 0);
    @(negedge clk);
    rstn = r[0]; en = e[0]; mode = md[2:0]; d = dv[7:0]; sin_l = sl[0]; sin_r = sr[0];
    @(posedge clk);
    #1;
    model_update(r, e, md, dv, sl, sr);
    check_all(tag);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; mode = 3'b001; d = 8'hFF; sin_l = 1'b0; sin_r = 1'b0;

    // reset held for two edges while a LOAD of FF is requested
    step("rst0", 0, 1, 1, 'hFF);
    step("rst1", 0, 1, 1, 'hFF);
    check("rst.q_lit", q, 64'h00);
    check("rst.qbar_lit", qbar, 64'hFF);

    // load / shift
    step("load_a5", 1, 1, 1, 'hA5);
    check("load.qbar_lit", qbar, 64'h5A);
    step("shl", 1, 1, 2, 0, 0, 1);
    check("shl.q_lit", q, 64'h4B);
    step("shr", 1, 1, 3, 0, 1, 0);
    check("shr.q_lit", q, 64'hA5);

    // 8 rotates right return to start and complete one word
    step("load_81", 1, 1, 1, 'h81);
    for (int i = 0; i < 8; i++) step($sformatf("ror%0d", i), 1, 1, 5);
    check("ror8.q_lit", q, 64'h81);
    check("ror8.done_lit", word_done, 64'd1);
    step("after_word", 1, 1, 0);

    // enable low freezes everything
    step("load_3c", 1, 1, 1, 'h3C);
    for (int i = 0; i < 5; i++) step($sformatf("en0_%0d", i), 1, 0, 2, 0, 1, 1);
    check("en0.q_lit", q, 64'h3C);

    // reset mid-word
    step("load_0f", 1, 1, 1, 'h0F);
    for (int i = 0; i < 3; i++) step($sformatf("rol%0d", i), 1, 1, 4);
    @(negedge clk);
    rstn = 1'b0; en = 1'b1; mode = 3'b100;
    #2;
    check("rstn_edge_only.q", q, 64'(m_q));
    check("rstn_edge_only.cnt", shift_cnt, 64'(m_cnt));
    @(posedge clk);
    #1;
    model_update(0, 1, 4, 0, 0, 0);
    check_all("mid_rst");
    for (int i = 0; i < 8; i++) step($sformatf("rol_post%0d", i), 1, 1, 4);
    check("rol_post.done_lit", word_done, 64'd1);

    // reserved mode
    step("load_5a", 1, 1, 1, 'h5A);
    step("rsvd", 1, 1, 7);
    check("rsvd.err_lit", mode_err, 64'd1);
    step("rsvd_after", 1, 1, 0);

    // clear and mixed directions
    step("clear", 1, 1, 6);
    for (int i = 0; i < 8; i++) step($sformatf("mix%0d", i), 1, 1, 2 + (i % 2), 0, i % 2, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 24) != 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
